// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches level/edge sources into a pending
// register, applies a software mask and drives registered HWInt lines to CP0.
module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h00007f30,
  parameter int          NSRC      = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Pr_Addr,
  input  logic [31:0]     Pr_WriteData,
  input  logic [3:0]      Pr_Byteen,
  output logic [31:0]     Pr_ReadData,
  input  logic [NSRC-1:0] Src,
  output logic [5:0]      HWInt
);

  logic [NSRC-1:0] pend_reg, pend_next;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] mode_reg;
  logic [NSRC-1:0] src_d_reg;
  logic [5:0]      hwint_reg, hwint_next;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] masked;

  logic        hit;
  logic        wr_en;
  logic [31:0] addr_word;
  logic        sel_pend, sel_mask, sel_mode, sel_clr, sel_vec;

  // Upper write-data bits are architecturally discarded.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, Pr_WriteData[31:NSRC]};

  assign hit       = (Pr_Addr >= BASE_ADDR) && (Pr_Addr <= BASE_ADDR + 32'h13);
  assign wr_en     = hit && (|Pr_Byteen);
  assign addr_word = {Pr_Addr[31:2], 2'b00};

  assign sel_pend = hit && (addr_word == BASE_ADDR);
  assign sel_mask = hit && (addr_word == BASE_ADDR + 32'h04);
  assign sel_mode = hit && (addr_word == BASE_ADDR + 32'h08);
  assign sel_clr  = hit && (addr_word == BASE_ADDR + 32'h0C);
  assign sel_vec  = hit && (addr_word == BASE_ADDR + 32'h10);

  assign clr_vec = (wr_en && sel_clr) ? Pr_WriteData[NSRC-1:0] : '0;
  assign masked  = pend_reg & mask_reg;

  // Edge-mode set has priority over a same-cycle clear.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      assign pend_next[gi] = mode_reg[gi]
                           ? ((pend_reg[gi] & ~clr_vec[gi]) | (Src[gi] & ~src_d_reg[gi]))
                           : Src[gi];
    end
    for (gi = 0; gi < 6; gi++) begin : g_hwint
      if (gi < NSRC) begin : g_used
        assign hwint_next[gi] = masked[gi];
      end else begin : g_unused
        assign hwint_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg  <= '0;
      mask_reg  <= '0;
      mode_reg  <= '0;
      src_d_reg <= '0;
      hwint_reg <= '0;
    end else begin
      pend_reg  <= pend_next;
      src_d_reg <= Src;
      hwint_reg <= hwint_next;
      if (wr_en && sel_mask) mask_reg <= Pr_WriteData[NSRC-1:0];
      if (wr_en && sel_mode) mode_reg <= Pr_WriteData[NSRC-1:0];
    end
  end

  assign HWInt = hwint_reg;

  logic [31:0] pend_ext, mask_ext, mode_ext;
  logic [2:0]  vec_idx;
  logic        vec_any;

  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    mode_ext = '0;
    vec_idx  = '0;
    vec_any  = |masked;
    for (int i = 0; i < NSRC; i++) begin
      pend_ext[i] = pend_reg[i];
      mask_ext[i] = mask_reg[i];
      mode_ext[i] = mode_reg[i];
    end
    // Scan downward so the lowest-numbered active source wins.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    Pr_ReadData = '0;
    if (sel_pend)     Pr_ReadData = pend_ext;
    else if (sel_mask) Pr_ReadData = mask_ext;
    else if (sel_mode) Pr_ReadData = mode_ext;
    else if (sel_vec)  Pr_ReadData = {vec_any, 28'd0, vec_idx};
  end

endmodule
